// File: rtl/sti_pkg.sv
// Shared definitions for the serial receive deserializer.
// Provides the word-length encoding, the receive FSM state type and helpers that turn
// a length code into a bit width or a data mask.
package sti_pkg;

  localparam logic [1:0] LEN8  = 2'd0;
  localparam logic [1:0] LEN16 = 2'd1;
  localparam logic [1:0] LEN24 = 2'd2;
  localparam logic [1:0] LEN32 = 2'd3;

  typedef enum logic {StIdle, StShift} state_e;

  // Word width in bits: 8 * (len + 1).
  function automatic logic [5:0] width_of(input logic [1:0] len);
    return 6'({len, 3'b000}) + 6'd8;
  endfunction

  // Mask keeping only the low width_of(len) bits.
  function automatic logic [31:0] word_mask(input logic [1:0] len);
    logic [31:0] m;
    unique case (len)
      LEN8:    m = 32'h0000_00ff;
      LEN16:   m = 32'h0000_ffff;
      LEN24:   m = 32'h00ff_ffff;
      default: m = 32'hffff_ffff;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/sti_rx_fifo.sv
// Small synchronous FIFO holding completed words (data + length code).
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   push_i, wdata_i    write request and entry; ignored when full unless popping too
//   pop_i              read request; ignored when empty
//   rdata_o            head entry, zero when empty
//   full_o, empty_o    occupancy flags
module sti_rx_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 34
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrW:0] DepthC = Depth[PtrW:0];

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DepthC);
  assign do_pop  = pop_i & ~empty_o;
  // A pop in the same cycle frees a slot, so a push into a full FIFO is still taken.
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/sti_deserializer.sv
// Serial receive stage: rebuilds 8/16/24/32-bit words from contiguous valid bit runs.
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-low reset
//   si_data, si_valid     serial bit stream and its qualifier
//   cfg_length, cfg_msb   word width code and bit order, sampled at word start only
//   out_data/len/valid    FIFO head (data zero-extended) with valid/ready handshake
//   out_ready             consumer accepts head when high with out_valid
//   err_trunc             one-cycle pulse when a run ends before the word completes
//   overflow, clr_status  sticky dropped-word flag and its synchronous clear
//   word_count            accepted words, wrapping 8-bit counter
module sti_deserializer
  import sti_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        si_data,
  input  logic        si_valid,
  input  logic [1:0]  cfg_length,
  input  logic        cfg_msb,
  output logic [31:0] out_data,
  output logic [1:0]  out_len,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        err_trunc,
  output logic        overflow,
  input  logic        clr_status,
  output logic [7:0]  word_count
);

  state_e      state_q, state_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [31:0] sh_q, sh_d;
  logic [1:0]  len_q, len_d;
  logic        msb_q, msb_d;
  logic        err_q, err_d;
  logic        ovf_q;
  logic [7:0]  cnt_q;

  logic        push, pop, accept, drop;
  logic        fifo_full, fifo_empty;
  logic [33:0] fifo_rdata;
  logic [31:0] push_data;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sh_d      = sh_q;
    len_d     = len_q;
    msb_d     = msb_q;
    err_d     = 1'b0;
    push      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (si_valid) begin
          // Shadow config so changes mid-word cannot corrupt the current word.
          len_d     = cfg_length;
          msb_d     = cfg_msb;
          sh_d      = {31'b0, si_data};
          bit_cnt_d = 6'd1;
          state_d   = StShift;
        end
      end
      StShift: begin
        if (si_valid) begin
          if (msb_q) begin
            sh_d = {sh_q[30:0], si_data};
          end else begin
            sh_d = sh_q;
            sh_d[bit_cnt_q[4:0]] = si_data;
          end
          if (bit_cnt_q == width_of(len_q) - 6'd1) begin
            push      = 1'b1;
            bit_cnt_d = '0;
            state_d   = StIdle;
          end else begin
            bit_cnt_d = bit_cnt_q + 6'd1;
          end
        end else begin
          err_d     = 1'b1;
          bit_cnt_d = '0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Push uses the shift value including the bit arriving this cycle.
  assign push_data = sh_d & word_mask(len_q);
  assign pop       = out_valid & out_ready;
  assign accept    = push & (~fifo_full | pop);
  assign drop      = push & fifo_full & ~pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      sh_q      <= '0;
      len_q     <= LEN8;
      msb_q     <= 1'b0;
      err_q     <= 1'b0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sh_q      <= sh_d;
      len_q     <= len_d;
      msb_q     <= msb_d;
      err_q     <= err_d;
      // A new drop wins over a clear in the same cycle.
      ovf_q     <= (ovf_q & ~clr_status) | drop;
      if (accept) cnt_q <= cnt_q + 8'd1;
    end
  end

  sti_rx_fifo #(
    .Depth (DEPTH),
    .Width (34)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (push),
    .wdata_i ({len_q, push_data}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign out_valid  = ~fifo_empty;
  assign out_data   = fifo_rdata[31:0];
  assign out_len    = fifo_rdata[33:32];
  assign err_trunc  = err_q;
  assign overflow   = ovf_q;
  assign word_count = cnt_q;

endmodule

// File: tb/tb_sti_deserializer.sv
// Self-checking bench for sti_deserializer: directed table, hand-written corner sequences
// and randomized traffic, all compared every cycle against a bit-list/queue reference model.
module tb_sti_deserializer;
  import sti_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        si_data, si_valid;
  logic [1:0]  cfg_length;
  logic        cfg_msb;
  logic [31:0] out_data;
  logic [1:0]  out_len;
  logic        out_valid, out_ready;
  logic        err_trunc, overflow, clr_status;
  logic [7:0]  word_count;

  always #5 clk = ~clk;

  sti_deserializer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .si_data    (si_data),
    .si_valid   (si_valid),
    .cfg_length (cfg_length),
    .cfg_msb    (cfg_msb),
    .out_data   (out_data),
    .out_len    (out_len),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .err_trunc  (err_trunc),
    .overflow   (overflow),
    .clr_status (clr_status),
    .word_count (word_count)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] d;
    logic [1:0]  l;
  } entry_t;

  entry_t      m_q[$];
  bit          m_bits[$];
  bit          m_active;
  logic [1:0]  m_len;
  bit          m_msb, m_err, m_ovf;
  logic [7:0]  m_cnt;

  int n_checks = 0;
  int n_errors = 0;
  bit rand_mode = 1'b0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_bits.delete();
    m_active = 1'b0;
    m_err    = 1'b0;
    m_ovf    = 1'b0;
    m_cnt    = '0;
  endtask

  // One clock edge of behaviour, computed from the inputs present at that edge.
  task automatic model_step();
    bit     pop, push, accept, drop;
    entry_t e, dummy;
    int     w;
    pop  = (m_q.size() != 0) && out_ready;
    push = 1'b0;
    m_err = 1'b0;
    e.d = '0;
    e.l = m_len;
    if (m_active) begin
      if (si_valid) begin
        m_bits.push_back(si_data);
        w = 8 * (int'(m_len) + 1);
        if (m_bits.size() == w) begin
          for (int i = 0; i < w; i++)
            if (m_bits[i]) e.d[m_msb ? (w - 1 - i) : i] = 1'b1;
          e.l = m_len;
          push = 1'b1;
          m_active = 1'b0;
          m_bits.delete();
        end
      end else begin
        m_err = 1'b1;
        m_active = 1'b0;
        m_bits.delete();
      end
    end else if (si_valid) begin
      m_len = cfg_length;
      m_msb = cfg_msb;
      m_bits.delete();
      m_bits.push_back(si_data);
      m_active = 1'b1;
    end
    accept = push && ((m_q.size() < DEPTH) || pop);
    drop   = push && !accept;
    if (pop) dummy = m_q.pop_front();
    if (accept) begin
      m_q.push_back(e);
      m_cnt = m_cnt + 8'd1;
    end
    m_ovf = (m_ovf && !clr_status) || drop;
  endtask

  // Every-cycle comparison of all outputs against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_out_valid", 32'(out_valid), 32'(m_q.size() != 0));
      check("cyc_out_data", out_data, (m_q.size() != 0) ? m_q[0].d : 32'h0);
      check("cyc_out_len", 32'(out_len), (m_q.size() != 0) ? 32'(m_q[0].l) : 32'h0);
      check("cyc_err_trunc", 32'(err_trunc), 32'(m_err));
      check("cyc_overflow", 32'(overflow), 32'(m_ovf));
      check("cyc_word_count", 32'(word_count), 32'(m_cnt));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input logic v, input logic d);
    si_valid = v;
    si_data  = d;
    if (rand_mode) begin
      out_ready  = 1'($urandom_range(0, 1));
      clr_status = ($urandom_range(0, 15) == 0);
    end
    @(posedge clk);
    if (reset) model_step();
    #1;
  endtask

  // Sends stream positions [from, to) of word w, without touching the config inputs.
  task automatic send_seq(input logic [31:0] w, input logic [1:0] len, input logic msb,
                          input int from, input int to);
    int wd;
    wd = 8 * (int'(len) + 1);
    for (int i = from; i < to; i++) tick(1'b1, msb ? w[wd - 1 - i] : w[i]);
  endtask

  task automatic send_word(input logic [31:0] w, input logic [1:0] len, input logic msb);
    cfg_length = len;
    cfg_msb    = msb;
    send_seq(w, len, msb, 0, 8 * (int'(len) + 1));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'h0);
    check({tag, "_out_data"}, out_data, 32'h0);
    check({tag, "_out_len"}, 32'(out_len), 32'h0);
    check({tag, "_err_trunc"}, 32'(err_trunc), 32'h0);
    check({tag, "_overflow"}, 32'(overflow), 32'h0);
    check({tag, "_word_count"}, 32'(word_count), 32'h0);
  endtask

  task automatic drain_expect(input string tag, input logic [31:0] exp_d);
    check({tag, "_valid"}, 32'(out_valid), 32'h1);
    check({tag, "_data"}, out_data, exp_d);
    out_ready = 1'b1;
    tick(1'b0, 1'b0);
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [31:0] d;
    logic [1:0]  len;
    logic        msb;
    logic        idle_after;
    logic [31:0] exp_d;
    logic [1:0]  exp_len;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [7:0] pat;
    int w, n;
    logic [1:0] l;
    logic m;
    logic [31:0] word;

    vecs[0] = '{32'h0000_beef, LEN16, 1'b0, 1'b0, 32'h0000_beef, LEN16};
    vecs[1] = '{32'h1234_5678, LEN32, 1'b0, 1'b1, 32'h1234_5678, LEN32};
    vecs[2] = '{32'h0000_00c3, LEN8,  1'b1, 1'b0, 32'h0000_00c3, LEN8};
    vecs[3] = '{32'hff89_abcd, LEN24, 1'b1, 1'b1, 32'h0089_abcd, LEN24};

    reset = 1'b0;
    si_valid = 1'b0;
    si_data = 1'b0;
    cfg_length = LEN8;
    cfg_msb = 1'b0;
    out_ready = 1'b0;
    clr_status = 1'b0;
    model_reset();
    chk_en = 1'b1;
    #1;
    check_reset_values("rst");
    @(posedge clk);
    #1;
    reset = 1'b1;

    // MSB-first 8-bit word from an explicit bit sequence.
    cfg_length = LEN8;
    cfg_msb = 1'b1;
    pat = 8'b1010_0101;
    for (int i = 7; i >= 0; i--) tick(1'b1, pat[i]);
    tick(1'b0, 1'b0);
    check("a5_valid", 32'(out_valid), 32'h1);
    check("a5_data", out_data, 32'h0000_00a5);
    check("a5_len", 32'(out_len), 32'h0);
    check("a5_count", 32'(word_count), 32'h1);
    out_ready = 1'b1;
    tick(1'b0, 1'b0);
    out_ready = 1'b0;
    check("a5_popped", 32'(out_valid), 32'h0);

    // Table: mixed widths and orders, including zero-gap back-to-back words.
    for (int i = 0; i < 4; i++) begin
      send_word(vecs[i].d, vecs[i].len, vecs[i].msb);
      if (vecs[i].idle_after) tick(1'b0, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      check($sformatf("tbl%0d_len", i), 32'(out_len), 32'(vecs[i].exp_len));
      drain_expect($sformatf("tbl%0d", i), vecs[i].exp_d);
    end
    check("tbl_empty", 32'(out_valid), 32'h0);

    // Truncated 24-bit run, then a good word.
    cfg_length = LEN24;
    cfg_msb = 1'b1;
    for (int i = 0; i < 10; i++) tick(1'b1, 1'($urandom_range(0, 1)));
    tick(1'b0, 1'b0);
    check("trunc_pulse", 32'(err_trunc), 32'h1);
    check("trunc_fifo", 32'(out_valid), 32'h0);
    tick(1'b0, 1'b0);
    check("trunc_pulse_end", 32'(err_trunc), 32'h0);
    send_word(32'h00ab_cdef, LEN24, 1'b1);
    tick(1'b0, 1'b0);
    check("trunc_next_len", 32'(out_len), 32'h2);
    drain_expect("trunc_next", 32'h00ab_cdef);

    // Config changes mid-word must not affect the word in flight.
    cfg_length = LEN24;
    cfg_msb = 1'b1;
    send_seq(32'h005a_3c96, LEN24, 1'b1, 0, 4);
    cfg_length = LEN8;
    cfg_msb = 1'b0;
    send_seq(32'h005a_3c96, LEN24, 1'b1, 4, 24);
    tick(1'b0, 1'b0);
    check("cfgchg_len", 32'(out_len), 32'h2);
    drain_expect("cfgchg", 32'h005a_3c96);

    // Reset mid 32-bit word with FIFO non-empty.
    send_word(32'h11, LEN8, 1'b1);
    send_word(32'h22, LEN8, 1'b0);
    cfg_length = LEN32;
    cfg_msb = 1'b0;
    send_seq(32'hdead_beef, LEN32, 1'b0, 0, 12);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_reset_values("midrst");
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check("postrst_err", 32'(err_trunc), 32'h0);
    check("postrst_valid", 32'(out_valid), 32'h0);

    // Overflow: five words into a 4-deep FIFO with no consumer.
    for (int k = 1; k <= 5; k++) send_word(32'(k), LEN8, 1'b1);
    tick(1'b0, 1'b0);
    check("ovf_flag", 32'(overflow), 32'h1);
    check("ovf_count", 32'(word_count), 32'h4);
    check("ovf_head", out_data, 32'h1);
    clr_status = 1'b1;
    tick(1'b0, 1'b0);
    clr_status = 1'b0;
    check("ovf_clr", 32'(overflow), 32'h0);

    // Full FIFO with a pop on the completion edge: word accepted.
    cfg_length = LEN8;
    cfg_msb = 1'b1;
    send_seq(32'h06, LEN8, 1'b1, 0, 7);
    out_ready = 1'b1;
    send_seq(32'h06, LEN8, 1'b1, 7, 8);
    out_ready = 1'b0;
    tick(1'b0, 1'b0);
    check("cpop_ovf", 32'(overflow), 32'h0);
    check("cpop_count", 32'(word_count), 32'h5);
    drain_expect("cpop0", 32'h2);
    drain_expect("cpop1", 32'h3);
    drain_expect("cpop2", 32'h4);
    drain_expect("cpop3", 32'h6);

    // Clear and new overflow in the same cycle: overflow stays set.
    for (int k = 0; k < 4; k++) send_word(32'(8 + k), LEN8, 1'b1);
    send_seq(32'h0d, LEN8, 1'b1, 0, 7);
    clr_status = 1'b1;
    send_seq(32'h0d, LEN8, 1'b1, 7, 8);
    clr_status = 1'b0;
    tick(1'b0, 1'b0);
    check("clrovf_flag", 32'(overflow), 32'h1);
    check("clrovf_count", 32'(word_count), 32'h9);
    clr_status = 1'b1;
    out_ready = 1'b1;
    repeat (4) tick(1'b0, 1'b0);
    clr_status = 1'b0;
    out_ready = 1'b0;

    // Randomized traffic against the model.
    rand_mode = 1'b1;
    repeat (300) begin
      l = 2'($urandom_range(0, 3));
      m = 1'($urandom_range(0, 1));
      word = $urandom;
      w = 8 * (int'(l) + 1);
      cfg_length = l;
      cfg_msb = m;
      if ($urandom_range(0, 7) == 0) begin
        n = $urandom_range(1, w - 1);
        send_seq(word, l, m, 0, n);
        tick(1'b0, 1'b0);
      end else begin
        send_seq(word, l, m, 0, w / 2);
        cfg_length = 2'($urandom_range(0, 3));
        cfg_msb = 1'($urandom_range(0, 1));
        send_seq(word, l, m, w / 2, w);
      end
      repeat ($urandom_range(0, 2)) tick(1'b0, 1'b0);
    end
    rand_mode = 1'b0;
    clr_status = 1'b0;
    out_ready = 1'b1;
    repeat (8) tick(1'b0, 1'b0);
    check("final_empty", 32'(out_valid), 32'h0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
